// File: rtl/sram_arbiter_if.sv
// Requester-side handshake bundle for sram_arbiter.
//   p0_*  : video frame-buffer read port (read-only, high priority)
//   p1_*  : host read/write port with byte enables
// The requester uses the master modport, the arbiter uses the slave modport.
interface sram_arbiter_if;
    logic        p0_req;
    logic [19:0] p0_addr;
    logic        p0_ack;
    logic [15:0] p0_rdata;

    logic        p1_req;
    logic        p1_we;
    logic [19:0] p1_addr;
    logic [15:0] p1_wdata;
    logic [1:0]  p1_be;
    logic        p1_ack;
    logic [15:0] p1_rdata;

    modport master (
        output p0_req, p0_addr, p1_req, p1_we, p1_addr, p1_wdata, p1_be,
        input  p0_ack, p0_rdata, p1_ack, p1_rdata
    );

    modport slave (
        input  p0_req, p0_addr, p1_req, p1_we, p1_addr, p1_wdata, p1_be,
        output p0_ack, p0_rdata, p1_ack, p1_rdata
    );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port arbiter owning a 1M x 16 asynchronous SRAM.
// Port 0 (video read) has priority; port 1 (host read/write) is forced through after
// STARVE_LIMIT consecutive port-0 grants made while it was waiting.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   bus (slave)     : p0/p1 request/ack handshakes and read data
//   busy            : high whenever an access is in flight
//   SRAM_*          : registered SRAM pins; SRAM_DQ is bidirectional
module sram_arbiter #(
    parameter int unsigned ACCESS_CYCLES = 2,
    parameter int unsigned STARVE_LIMIT  = 4
) (
    input  logic          clk,
    input  logic          reset,
    sram_arbiter_if.slave bus,
    output logic          busy,
    inout  wire  [15:0]   SRAM_DQ,
    output logic [19:0]   SRAM_ADDR,
    output logic          SRAM_LB_N,
    output logic          SRAM_UB_N,
    output logic          SRAM_CE_N,
    output logic          SRAM_OE_N,
    output logic          SRAM_WE_N
);

    localparam int unsigned CntW        = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(ACCESS_CYCLES - 1);
    localparam logic [7:0] StarveLimit  = 8'(STARVE_LIMIT);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            port_q, port_d;
    logic            we_q, we_d;
    logic [19:0]     addr_q, addr_d;
    logic [1:0]      be_q, be_d;
    logic [15:0]     wdata_q, wdata_d;
    logic [7:0]      starve_q, starve_d;
    logic [15:0]     p0_rdata_q, p0_rdata_d;
    logic [15:0]     p1_rdata_q, p1_rdata_d;

    // Registered pin state
    logic [19:0]     sram_addr_q, sram_addr_d;
    logic            ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
    logic            lb_n_q, lb_n_d, ub_n_q, ub_n_d;
    logic            dq_oe_q, dq_oe_d;
    logic [15:0]     dq_out_q, dq_out_d;

    logic            force_p1;

    assign force_p1 = bus.p1_req && (STARVE_LIMIT != 0) && (starve_q == StarveLimit);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            port_q      <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            starve_q    <= '0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
            sram_addr_q <= '0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            lb_n_q      <= 1'b1;
            ub_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
            dq_out_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            port_q      <= port_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            starve_q    <= starve_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
            sram_addr_q <= sram_addr_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            lb_n_q      <= lb_n_d;
            ub_n_q      <= ub_n_d;
            dq_oe_q     <= dq_oe_d;
            dq_out_q    <= dq_out_d;
        end
    end

    // Next-state: grant, access sequencing, read capture
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        port_d     = port_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        starve_d   = starve_q;
        p0_rdata_d = p0_rdata_q;
        p1_rdata_d = p1_rdata_q;
        case (state_q)
            StIdle: begin
                if (force_p1 || (!bus.p0_req && bus.p1_req)) begin
                    port_d   = 1'b1;
                    we_d     = bus.p1_we;
                    addr_d   = bus.p1_addr;
                    be_d     = bus.p1_be;
                    wdata_d  = bus.p1_wdata;
                    starve_d = '0;
                    cnt_d    = CntLoad;
                    state_d  = StAccess;
                end else if (bus.p0_req) begin
                    port_d  = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = bus.p0_addr;
                    be_d    = 2'b11;
                    cnt_d   = CntLoad;
                    state_d = StAccess;
                    // Only grants that bypass a waiting port 1 count toward starvation
                    if (bus.p1_req && (starve_q != 8'hFF)) begin
                        starve_d = starve_q + 8'd1;
                    end
                end
            end
            StAccess: begin
                if (cnt_q == '0) begin
                    state_d = StDone;
                    if (!we_q) begin
                        if (port_q) p1_rdata_d = SRAM_DQ;
                        else        p0_rdata_d = SRAM_DQ;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs: pin values are derived from the next state so they land in the pin
    // registers exactly when the state machine enters that state.
    always_comb begin
        sram_addr_d = sram_addr_q;
        ce_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        we_n_d      = 1'b1;
        lb_n_d      = 1'b1;
        ub_n_d      = 1'b1;
        dq_oe_d     = 1'b0;
        dq_out_d    = dq_out_q;
        case (state_d)
            StAccess: begin
                ce_n_d      = 1'b0;
                sram_addr_d = addr_d;
                if (we_d) begin
                    we_n_d   = 1'b0;
                    lb_n_d   = ~be_d[0];
                    ub_n_d   = ~be_d[1];
                    dq_oe_d  = 1'b1;
                    dq_out_d = wdata_d;
                end else begin
                    oe_n_d = 1'b0;
                    lb_n_d = 1'b0;
                    ub_n_d = 1'b0;
                end
            end
            // Keep write data on the bus one cycle past WE_N rising for hold time
            StDone:  dq_oe_d = we_d;
            default: ;
        endcase

        bus.p0_ack = (state_q == StDone) && !port_q;
        bus.p1_ack = (state_q == StDone) && port_q;
        busy       = (state_q != StIdle);
    end

    assign bus.p0_rdata = p0_rdata_q;
    assign bus.p1_rdata = p1_rdata_q;

    assign SRAM_DQ   = dq_oe_q ? dq_out_q : 16'hzzzz;
    assign SRAM_ADDR = sram_addr_q;
    assign SRAM_CE_N = ce_n_q;
    assign SRAM_OE_N = oe_n_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_LB_N = lb_n_q;
    assign SRAM_UB_N = ub_n_q;

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
Shares the single off-chip 16-bit asynchronous SRAM (1M x 16, 20-bit word address) between two requesters. Port 0 is the video frame-buffer reader: read-only, high priority. Port 1 is the host read/write port with byte enables. The block owns the SRAM pins, sequences each access with a fixed cycle count, and applies bounded-starvation priority so port 1 always makes progress.

Parameters:
ACCESS_CYCLES, 2, cycles the SRAM pins stay asserted per access; minimum 1; 2 gives 40 ns at 50 MHz.
STARVE_LIMIT, 4, consecutive port-0 grants allowed while port 1 is pending before port 1 is forced; 0 gives strict port-0 priority; maximum 255.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
p0_req  in  1  port 0 read request; held with p0_addr until p0_ack
p0_addr  in  20  port 0 word address
p0_ack  out  1  one-cycle pulse; p0_rdata valid in the same cycle
p0_rdata  out  16  port 0 read data; held until the next port-0 read completes
p1_req  in  1  port 1 request; held with all p1_* inputs until p1_ack
p1_we  in  1  1 = write, 0 = read
p1_addr  in  20  port 1 word address
p1_wdata  in  16  write data
p1_be  in  2  byte enables for writes; [0] = low byte, [1] = high byte
p1_ack  out  1  one-cycle completion pulse; p1_rdata valid for reads
p1_rdata  out  16  port 1 read data; held until the next port-1 read completes
busy  out  1  high whenever state is not IDLE
SRAM_DQ  inout  16  SRAM data bus
SRAM_ADDR  out  20  SRAM address
SRAM_LB_N, SRAM_UB_N, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N  out  1 each  active-low SRAM controls

Behaviour:
- Reset and outputs:
  - All SRAM pins are registered.
  - On reset: all *_N outputs = 1, SRAM_ADDR = 0, SRAM_DQ = Z, acks = 0, rdata = 0, busy = 0, starve count = 0, state = IDLE.
- State machine: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - Samples requests.
  - If any grant is made, latch port ID, address, we, be and wdata, then go to ACCESS.
  - With no request, stay in IDLE with all pins deasserted.
- Grant rule in IDLE:
  - If p1_req is high, STARVE_LIMIT != 0 and starve_cnt == STARVE_LIMIT, grant port 1.
  - Else if p0_req is high, grant port 0.
  - Else if p1_req is high, grant port 1.
- Starve counter:
  - Increments, saturating, on each port-0 grant made while p1_req is high.
  - Clears on every port-1 grant.
  - Unchanged otherwise.
- ACCESS, held for ACCESS_CYCLES cycles via down-counter:
  - CE_N = 0 and SRAM_ADDR = latched address.
  - Read: OE_N = 0, WE_N = 1, LB_N = UB_N = 0, DQ = Z.
  - Write: OE_N = 1, WE_N = 0, LB_N = ~be[0], UB_N = ~be[1], DQ driven with wdata.
  - On the last ACCESS cycle, reads capture SRAM_DQ into the granted port's rdata register.
- DONE, one cycle:
  - CE_N, OE_N, WE_N, LB_N and UB_N all return to 1.
  - For writes, DQ stays driven with wdata (data hold after WE_N rises); DQ = Z for reads.
  - Granted port's ack = 1 in this cycle.
  - Next state is always IDLE.
- Latency and throughput:
  - Request sampled in IDLE at cycle T -> ack at T+ACCESS_CYCLES+1.
  - Next request sampled at T+ACCESS_CYCLES+2.
  - Peak throughput is one access per ACCESS_CYCLES+2 cycles.
- Handshake:
  - The requester may drop req in its ack cycle.
  - A req still high in the cycle after ack is a new request.
  - Changing p*_addr or p1_* while req is high and before ack is illegal; the latched values are used.
- Data-bus direction: DQ is never driven in IDLE, in read ACCESS, or in read DONE. No cycle has OE_N = 0 while DQ is driven.
- Write with p1_be = 0: full sequence runs, LB_N = UB_N = 1 (no bytes written), ack is still given.
- Simultaneous p0_req and p1_req: resolved only by the grant rule; both acks are never high in the same cycle.
- Reset mid-access: the access is aborted the cycle reset is sampled. Pins go to reset values, DQ = Z, and no ack is issued for the aborted request.

Test Plan:
- Port-0 read: preload SRAM model addr 0x00010 = 0xBEEF; p0_req with addr 0x00010 at cycle T -> CE_N/OE_N low on cycles T+1..T+2, p0_ack and p0_rdata = 0xBEEF at T+3, busy low at T+4.
- Port-1 byte write then read: write addr 0xFFFFF, wdata 0x1234, be = 2'b01 over model holding 0xAAAA -> WE_N low 2 cycles, UB_N = 1, model reads 0xAA34; follow-up read returns p1_rdata = 0xAA34.
- Starvation: p0_req and p1_req held continuously, STARVE_LIMIT = 4 -> grant order 0,0,0,0,1,0,0,0,0,1; each access is spaced 4 cycles apart.
- STARVE_LIMIT = 0, both requests held -> 10 consecutive port-0 acks and no p1_ack.
- Bus turnaround: write immediately followed by read -> DQ driven through write DONE, Z in the following IDLE, OE_N never low while DQ is driven (checked every cycle).
- Reset in the second ACCESS cycle of a write -> next cycle WE_N = CE_N = 1, DQ = Z, no p1_ack; a fresh p1 read afterwards completes normally.
